// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART blocks: receiver state encoding, data
//   width, and the baud-timing helpers (also used by the future transmitter).
//   Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } uart_state_e;

    // Clock cycles per bit, integer-truncated.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Cycles from a start edge to mid-bit.
    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// synchronizer
//   Flop chain for bringing an asynchronous level into the clk domain.
//   Resets to 1 so an idle-high serial line does not look like an edge.
// Ports:
//   clk   core clock
//   rst   asynchronous active-low reset
//   d     asynchronous input
//   q     synchronised output (DEPTH cycles of latency)
module synchronizer #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain <= '1;
        else      chain <= {chain[DEPTH-2:0], d};
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 serial deframer (8E1 when UART_RX_PARITY_EN is defined) with a
//   one-entry valid/ready holding register for the CPU's UART loads.
// Ports:
//   clk             core clock
//   rst             asynchronous active-low reset
//   serial_in       raw RX line, idles high, asynchronous to clk
//   data_out        received byte, LSB first on the wire
//   data_out_valid  data_out holds an unconsumed byte
//   data_out_ready  consumer takes the byte this cycle
//   frame_err       1-cycle pulse on bad stop bit (or parity mismatch)
//   overrun_err     1-cycle pulse when a good byte is dropped (register full)
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data bit 7).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       serial_in,
    output logic [UART_DATA_WIDTH-1:0] data_out,
    output logic                       data_out_valid,
    input  logic                       data_out_ready,
    output logic                       frame_err,
    output logic                       overrun_err
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic                       rx_sync;
    logic                       rx_prev;
    uart_state_e                state, state_nxt;
    logic [CNT_W-1:0]           cnt;
    logic [2:0]                 bit_cnt;
    logic [UART_DATA_WIDTH-1:0] shift_q;
    logic                       byte_done;
    logic                       cnt_clr, shift_en, stop_smp;
    logic                       frame_good;

    synchronizer #(.DEPTH(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_sync)
    );

    // Previous synchronised value, for falling-edge detection in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_prev <= 1'b1;
        else      rx_prev <= rx_sync;
    end

`ifdef UART_RX_PARITY_EN
    logic par_smp;
    logic par_err;

    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         par_err <= 1'b0;
        else if (par_smp) par_err <= (^shift_q) ^ rx_sync;
    end

    assign frame_good = rx_sync && !par_err;
`else
    assign frame_good = rx_sync;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here was only a glitch.
                if (cnt == MID_CNT) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == END_CNT) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == END_CNT) begin
                    cnt_clr   = 1'b1;
                    par_smp   = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid stop bit gives half a bit of slack before
                // a back-to-back start edge.
                if (cnt == END_CNT) begin
                    cnt_clr   = 1'b1;
                    stop_smp  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shift_q <= '0;
        end else begin
            if (cnt_clr)              cnt <= '0;
            else if (state != ST_IDLE) cnt <= cnt + 1'b1;

            if (state == ST_START)    bit_cnt <= 3'd0;
            else if (shift_en)        bit_cnt <= bit_cnt + 3'd1;

            // LSB arrives first, so shift in at the top.
            if (shift_en) shift_q <= {rx_sync, shift_q[UART_DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= stop_smp && frame_good;
            frame_err <= stop_smp && !frame_good;
        end
    end

    // Holding register. A byte completing while the old one is being taken
    // replaces it without loss; otherwise a full register drops the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun_err    <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (byte_done) begin
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= shift_q;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Scoreboarded bench for uart_receiver at 10 clocks per bit. Expected bytes
//   are queued when a frame is sent and popped on each valid/ready handshake.
module tb_uart_receiver;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int BIT_CYC    = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 109;
`else
    localparam int LAT = 99;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_err;
    logic       overrun_err;

    uart_receiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_sent = 0;
    int         fall_cyc = 0;
    int         valid_rise_cyc = -1;
    int         vld_cycles = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    logic       vld_q = 1'b0;
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (data_out_valid && !vld_q) valid_rise_cyc = cyc;
        vld_q = data_out_valid;
        if (data_out_valid) vld_cycles++;
        if (frame_err)      n_ferr++;
        if (overrun_err)    n_ovr++;
        if (data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
            else                   chk("sb_byte", 32'(data_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame LSB first; entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        serial_in = 1'b0;
        fall_cyc  = cyc;
        n_sent++;
        hold(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            hold(BIT_CYC);
        end
`ifdef UART_RX_PARITY_EN
        serial_in = (^d) ^ par_flip;
        hold(BIT_CYC);
`endif
        serial_in = stop_bit;
        hold(BIT_CYC);
        serial_in = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0, v0, s0;

        // Reset state
        hold(3);
        chk("rst_data",  32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_out_valid), 32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_ovr",   32'(overrun_err), 32'h0);
        rst = 1'b1;
        hold(5);

        // Single byte, ready held high
        data_out_ready = 1'b1;
        f0 = n_ferr; o0 = n_ovr; v0 = vld_cycles; valid_rise_cyc = -1;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        hold(5);
        chk("a5_latency",  32'(valid_rise_cyc - fall_cyc), 32'(LAT));
        chk("a5_vld_1cyc", 32'(vld_cycles - v0), 32'd1);
        chk("a5_no_ferr",  32'(n_ferr - f0), 32'd0);
        chk("a5_no_ovr",   32'(n_ovr - o0), 32'd0);
        chk("a5_drained",  32'(exp_q.size()), 32'd0);

        // Short low glitch in IDLE is a false start
        f0 = n_ferr; v0 = vld_cycles;
        serial_in = 1'b0;
        hold(3);
        serial_in = 1'b1;
        hold(20);
        chk("glitch_no_valid", 32'(vld_cycles - v0), 32'd0);
        chk("glitch_no_ferr",  32'(n_ferr - f0), 32'd0);
        valid_rise_cyc = -1;
        exp_q.push_back(8'h96);
        send_byte(8'h96, 1'b1);
        hold(5);
        chk("post_glitch_latency", 32'(valid_rise_cyc - fall_cyc), 32'(LAT));
        chk("post_glitch_drained", 32'(exp_q.size()), 32'd0);

        // Bad stop bit
        f0 = n_ferr; v0 = vld_cycles;
        send_byte(8'h3C, 1'b0);
        hold(20);
        chk("stop0_ferr_once", 32'(n_ferr - f0), 32'd1);
        chk("stop0_no_valid",  32'(vld_cycles - v0), 32'd0);
        chk("stop0_valid_low", 32'(data_out_valid), 32'd0);

        // Overrun: two back-to-back bytes, nobody reading
        data_out_ready = 1'b0;
        o0 = n_ovr;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        hold(3);
        chk("ovr_pulse",    32'(n_ovr - o0), 32'd1);
        chk("ovr_kept_old", 32'(data_out), 32'h11);
        chk("ovr_valid",    32'(data_out_valid), 32'd1);
        data_out_ready = 1'b1;
        hold(1);
        data_out_ready = 1'b0;
        hold(2);
        chk("ovr_drained",   32'(exp_q.size()), 32'd0);
        chk("ovr_valid_clr", 32'(data_out_valid), 32'd0);

        // Ready raised exactly in the second byte's completion cycle
        o0 = n_ovr; s0 = n_sent;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send_byte(8'h11, 1'b1);
                send_byte(8'h22, 1'b1);
            end
            begin
                wait (n_sent == s0 + 2);
                repeat (98) @(posedge clk);
                #1 data_out_ready = 1'b1;
                @(posedge clk);
                #1 data_out_ready = 1'b0;
            end
        join
        hold(3);
        chk("swap_no_ovr",  32'(n_ovr - o0), 32'd0);
        chk("swap_new",     32'(data_out), 32'h22);
        chk("swap_valid",   32'(data_out_valid), 32'd1);
        chk("swap_pending", 32'(exp_q.size()), 32'd1);
        data_out_ready = 1'b1;
        hold(1);
        data_out_ready = 1'b0;
        hold(2);
        chk("swap_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of data bit 4
        send_byte(8'h33, 1'b1);
        hold(2);
        chk("pre_rst_held", 32'(data_out), 32'h33);
        s0 = n_sent;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                wait (n_sent == s0 + 1);
                repeat (55) @(posedge clk);
                #2 rst = 1'b0;
                #1;
                chk("midrst_data",  32'(data_out), 32'h0);
                chk("midrst_valid", 32'(data_out_valid), 32'h0);
                chk("midrst_ferr",  32'(frame_err), 32'h0);
                chk("midrst_ovr",   32'(overrun_err), 32'h0);
                @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        f0 = n_ferr;
        hold(20);
        chk("postrst_no_ferr",  32'(n_ferr - f0), 32'd0);
        chk("postrst_no_valid", 32'(data_out_valid), 32'd0);
        data_out_ready = 1'b1;
        valid_rise_cyc = -1;
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        hold(5);
        chk("postrst_latency", 32'(valid_rise_cyc - fall_cyc), 32'(LAT));
        chk("postrst_drained", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity: correct bit accepted, flipped bit rejected
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1);
        hold(5);
        chk("par_ok_drained", 32'(exp_q.size()), 32'd0);
        par_flip = 1'b1;
        f0 = n_ferr; v0 = vld_cycles;
        send_byte(8'h07, 1'b1);
        hold(20);
        chk("par_bad_ferr",  32'(n_ferr - f0), 32'd1);
        chk("par_bad_novld", 32'(vld_cycles - v0), 32'd0);
        par_flip = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
